// File: rtl/transpose_pingpong_ram_if.sv
// Stream bundle for the ping-pong transpose RAM: tile input stream with mode bit,
// and replay output stream with end-of-tile marker.
interface transpose_pingpong_ram_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              tr_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, tr_mode, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, tr_mode, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/transpose_pingpong_ram.sv
// Double-buffered N x N tile store: one bank fills in raster order while the other
// replays its tile either in raster or transposed order.
module transpose_pingpong_ram #(
  parameter int DATA_W = 16,
  parameter int N      = 8
) (
  input  logic                    clk,
  input  logic                    clr_n,
  transpose_pingpong_ram_if.slave bus
);
  localparam int LW    = $clog2(N);
  localparam int AW    = 2 * LW;
  localparam int DEPTH = N * N;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

  bank_state_e       state_q [2];
  bank_state_e       state_d [2];
  logic              mode_q  [2];
  logic              mode_d  [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [AW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  // Both banks live in one array; the bank pointer is the top address bit.
  logic [DATA_W-1:0] mem [2*DEPTH];

  logic          in_ready;
  logic          wr_fire;
  logic          rd_avail;
  logic          rd_load;
  logic [LW-1:0] rd_i;
  logic [LW-1:0] rd_j;
  logic [AW-1:0] rd_addr;

  // Gated by clr_n so the input side reports not-ready throughout reset.
  assign in_ready = clr_n & ((state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING));
  assign wr_fire  = bus.in_valid & in_ready;
  assign rd_avail = (state_q[rd_bank_q] == FULL) || (state_q[rd_bank_q] == DRAINING);
  assign rd_load  = rd_avail & (~out_valid_q | bus.out_ready);

  assign rd_i    = rd_cnt_q[AW-1:LW];
  assign rd_j    = rd_cnt_q[LW-1:0];
  assign rd_addr = mode_q[rd_bank_q] ? {rd_j, rd_i} : rd_cnt_q;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      mode_d[b]  = mode_q[b];
    end
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    if (wr_fire) begin
      if (wr_cnt_q == '0) begin
        state_d[wr_bank_q] = FILLING;
        mode_d[wr_bank_q]  = bus.tr_mode;
      end
      if (wr_cnt_q == LAST_IDX) begin
        state_d[wr_bank_q] = FULL;
        wr_cnt_d           = '0;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end

    // Write and read always target different banks, so their state updates never collide.
    if (rd_load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem[{rd_bank_q, rd_addr}];
      out_last_d  = (rd_cnt_q == LAST_IDX);
      if (rd_cnt_q == LAST_IDX) begin
        state_d[rd_bank_q] = EMPTY;
        rd_cnt_d           = '0;
        rd_bank_d          = ~rd_bank_q;
      end else begin
        state_d[rd_bank_q] = DRAINING;
        rd_cnt_d           = rd_cnt_q + AW'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= EMPTY;
        mode_q[b]  <= 1'b0;
      end
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        mode_q[b]  <= mode_d[b];
      end
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Tile storage carries no reset; stale words are never read before being rewritten.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank_q, wr_cnt_q}] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_transpose_pingpong_ram.sv
// Bench for transpose_pingpong_ram: scoreboard of expected replay words plus
// directed sequences for backpressure, streaming and mid-tile reset.
module tb_transpose_pingpong_ram;
  localparam int DATA_W = 16;
  localparam int N      = 8;
  localparam int DEPTH  = N * N;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  typedef struct {
    logic mode;
    int   base;
    int   exp_second;
    int   exp_k8;
    int   exp_final;
  } vec_t;

  logic clk;
  logic clr_n;

  transpose_pingpong_ram_if #(.DATA_W(DATA_W)) bus ();

  transpose_pingpong_ram #(.DATA_W(DATA_W), .N(N)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t              sb_q  [$];
  logic [DATA_W-1:0] got_q [$];
  int n_chk   = 0;
  int n_fail  = 0;
  bit mon_en  = 0;
  bit bub_en  = 0;
  bit seen_out = 0;
  int bubbles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected replay order of one tile, from the mode latched with its first word.
  task automatic push_tile(input int base, input bit mode);
    exp_t e;
    for (int k = 0; k < DEPTH; k++) begin
      int i = k / N;
      int j = k % N;
      e.data = DATA_W'(mode ? base + j * N + i : base + k);
      e.last = (k == DEPTH - 1);
      sb_q.push_back(e);
    end
  endtask

  // Offers consecutive words; with toggle set, tr_mode flips every 5 words mid-tile.
  task automatic drive(input int base, input int nwords, input bit mode, input bit toggle,
                       input int maxcyc, output int acc, output int cyc);
    bit hs;
    acc = 0;
    cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(base);
    bus.tr_mode  = mode;
    while (acc < nwords && cyc < maxcyc) begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
        acc++;
        bus.in_data = DATA_W'(base + acc);
        bus.tr_mode = (toggle && ((acc / 5) % 2 == 1)) ? ~mode : mode;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int maxcyc);
    int c = 0;
    while (sb_q.size() != 0 && c < maxcyc) begin
      @(negedge clk);
      c++;
    end
    check("drain_remaining", sb_q.size(), 0);
    repeat (3) @(negedge clk);
    check("no_residual_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d expected no word", bus.out_data);
      end else begin
        e = sb_q.pop_front();
        check("out_data", bus.out_data, e.data);
        check("out_last", bus.out_last, e.last);
      end
    end
  end

  always @(negedge clk) begin
    if (bub_en) begin
      if (bus.out_valid) seen_out = 1;
      else if (seen_out && sb_q.size() != 0) bubbles++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [4];
    int   acc, cyc, e, total;
    bit   modes [4];

    vecs[0] = '{mode: 1'b1, base: 0,    exp_second: 8,    exp_k8: 1,    exp_final: 63};
    vecs[1] = '{mode: 1'b0, base: 0,    exp_second: 1,    exp_k8: 8,    exp_final: 63};
    vecs[2] = '{mode: 1'b1, base: 1000, exp_second: 1008, exp_k8: 1001, exp_final: 1063};
    vecs[3] = '{mode: 1'b0, base: 500,  exp_second: 501,  exp_k8: 508,  exp_final: 563};
    modes[0] = 1'b1; modes[1] = 1'b0; modes[2] = 1'b1; modes[3] = 1'b0;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.tr_mode   = 1'b0;
    bus.out_ready = 1'b0;
    clr_n         = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    check("rel_in_ready", bus.in_ready, 1);
    check("rel_out_valid", bus.out_valid, 0);
    check("rel_out_data", bus.out_data, 0);
    @(posedge clk);
    #1;
    mon_en = 1;
    bus.out_ready = 1'b1;

    // Single tiles from idle, raster and transposed
    foreach (vecs[v]) begin
      got_q.delete();
      push_tile(vecs[v].base, vecs[v].mode);
      drive(vecs[v].base, DEPTH, vecs[v].mode, 1'b0, 200, acc, cyc);
      check("vec_accepted", acc, DEPTH);
      check("vec_in_cycles", cyc, DEPTH);
      @(negedge clk);
      check("vec_latency_e1", bus.out_valid, 0);
      @(negedge clk);
      check("vec_latency_e2", bus.out_valid, 1);
      wait_drain(200);
      check("vec_count", got_q.size(), DEPTH);
      if (got_q.size() == DEPTH) begin
        check("vec_first", got_q[0], vecs[v].base);
        check("vec_second", got_q[1], vecs[v].exp_second);
        check("vec_k8", got_q[8], vecs[v].exp_k8);
        check("vec_final", got_q[DEPTH-1], vecs[v].exp_final);
      end
    end

    // Backpressure: both banks fill, output holds word 0
    bus.out_ready = 1'b0;
    push_tile(0, 1'b0);
    push_tile(64, 1'b0);
    drive(0, 200, 1'b0, 1'b0, 150, acc, cyc);
    check("bp_accepted", acc, 128);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_out_data", bus.out_data, 0);
    check("bp_out_last", bus.out_last, 0);
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      check("bp_hold_data", bus.out_data, 0);
      check("bp_hold_valid", bus.out_valid, 1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    e = 0;
    while (e < 100) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (bus.in_ready) break;
    end
    check("bp_ready_rise_edges", e, 63);
    @(posedge clk);
    #1;
    push_tile(128, 1'b0);
    drive(128, DEPTH, 1'b0, 1'b0, 200, acc, cyc);
    check("bp_tile2_accepted", acc, DEPTH);
    wait_drain(300);

    // Streaming, alternating mode with tr_mode toggling mid-tile
    bubbles  = 0;
    seen_out = 0;
    bub_en   = 1;
    total    = 0;
    for (int t = 0; t < 4; t++) begin
      push_tile(1000 * (t + 1), modes[t]);
      drive(1000 * (t + 1), DEPTH, modes[t], 1'b1, 200, acc, cyc);
      check("stream_accepted", acc, DEPTH);
      total += cyc;
    end
    check("stream_in_cycles", total, 4 * DEPTH);
    wait_drain(300);
    bub_en = 0;
    check("stream_bubbles", bubbles, 0);

    // Reset while tile 1 drains and tile 2 is partially written
    got_q.delete();
    push_tile(0, 1'b1);
    drive(0, DEPTH, 1'b1, 1'b0, 200, acc, cyc);
    drive(300, 30, 1'b0, 1'b0, 100, acc, cyc);
    check("rst_mid_partial_accepted", acc, 30);
    #2;
    clr_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_out_last", bus.out_last, 0);
    check("rst_mid_in_ready", bus.in_ready, 0);
    check("rst_mid_drained_words", got_q.size(), 29);
    sb_q.delete();
    got_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    check("rst_mid_rel_in_ready", bus.in_ready, 1);
    check("rst_mid_rel_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    push_tile(100, 1'b0);
    drive(100, DEPTH, 1'b0, 1'b0, 200, acc, cyc);
    check("rst_fresh_accepted", acc, DEPTH);
    wait_drain(200);
    check("rst_fresh_count", got_q.size(), DEPTH);
    if (got_q.size() == DEPTH) begin
      check("rst_fresh_first", got_q[0], 100);
      check("rst_fresh_final", got_q[DEPTH-1], 163);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
